// File: rtl/alu_pkg.sv
// Shared ALU definitions: condition-code encodings, NZCV flag bit positions
// and the default datapath width.
package alu_pkg;

  localparam int DATA_W = 5;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_check.sv
// Purely combinational condition evaluator: (NZCV flags, cond) -> pass.
// Kept standalone so branch logic can reuse it.
module cond_check
  import alu_pkg::*;
(
  input  logic [3:0] flags,
  input  logic [3:0] cond,
  output logic       pass
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    pass = 1'b1;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c & !z;
      COND_LS: pass = !c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b1;  // 1111 behaves as AL
    endcase
  end

endmodule

// File: rtl/alu_cond_stage.sv
// Execute-stage back end: conditional execution against the NZCV register,
// one-entry output register with valid/ready. ALU_COND_STATS_EN adds counters.
module alu_cond_stage
  import alu_pkg::*;
#(
  parameter int DATA_W = alu_pkg::DATA_W,
  parameter int DEST_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_result,
  input  logic [3:0]        in_flags,
  input  logic [3:0]        in_cond,
  input  logic              in_set_flags,
  input  logic [DEST_W-1:0] in_dest,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [DEST_W-1:0] out_dest,
  output logic              out_write,
`ifdef ALU_COND_STATS_EN
  output logic [7:0]        exec_count,
  output logic [7:0]        squash_count,
`endif
  output logic [3:0]        flags_q
);

  logic accept;
  logic pass;

  assign in_ready = !out_valid | out_ready;
  assign accept   = in_valid & in_ready;

  // Evaluated against the pre-update register; the same edge that captures
  // this beat writes the new flags, which the next beat then sees.
  cond_check u_cond_check (
    .flags (flags_q),
    .cond  (in_cond),
    .pass  (pass)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_dest   <= '0;
      out_write  <= 1'b0;
      flags_q    <= 4'b0000;
    end else begin
      if (accept) begin
        out_valid  <= 1'b1;
        out_result <= in_result;
        out_dest   <= in_dest;
        out_write  <= pass;
        if (pass && in_set_flags) flags_q <= in_flags;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef ALU_COND_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      exec_count   <= 8'h00;
      squash_count <= 8'h00;
    end else if (accept) begin
      if (pass && exec_count != 8'hFF)     exec_count   <= exec_count + 8'h01;
      if (!pass && squash_count != 8'hFF)  squash_count <= squash_count + 8'h01;
    end
  end
`endif

endmodule

// File: tb/tb_alu_cond_stage.sv
module tb_alu_cond_stage;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] in_result;
  logic [3:0] in_flags;
  logic [3:0] in_cond;
  logic       in_set_flags;
  logic [2:0] in_dest;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] out_result;
  logic [2:0] out_dest;
  logic       out_write;
  logic [3:0] flags_q;
`ifdef ALU_COND_STATS_EN
  logic [7:0] exec_count;
  logic [7:0] squash_count;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_cond_stage #(.DATA_W(5), .DEST_W(3)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_result    (in_result),
    .in_flags     (in_flags),
    .in_cond      (in_cond),
    .in_set_flags (in_set_flags),
    .in_dest      (in_dest),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_dest     (out_dest),
    .out_write    (out_write),
`ifdef ALU_COND_STATS_EN
    .exec_count   (exec_count),
    .squash_count (squash_count),
`endif
    .flags_q      (flags_q)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [4:0] r, input logic [3:0] f, input logic [3:0] c,
                      input logic sf, input logic [2:0] d);
    in_valid     = 1'b1;
    in_result    = r;
    in_flags     = f;
    in_cond      = c;
    in_set_flags = sf;
    in_dest      = d;
    @(posedge clk); #1;
    in_valid     = 1'b0;
  endtask

  initial begin
    #100000;
    errors++;
    $error("FAIL timeout: bench did not finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_result = '0; in_flags = '0; in_cond = '0; in_set_flags = 1'b0; in_dest = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    chk("rst_flags", flags_q, 4'b0000);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_write", out_write, 1'b0);
    chk("rst_out_result", out_result, 5'h00);

    beat(5'h00, 4'b0100, 4'b1110, 1'b1, 3'd1);
    chk("al_valid", out_valid, 1'b1);
    chk("al_write", out_write, 1'b1);
    chk("al_dest", out_dest, 3'd1);
    chk("al_flags", flags_q, 4'b0100);
    beat(5'h0A, 4'b0000, 4'b0000, 1'b0, 3'd2);
    chk("eq_write", out_write, 1'b1);
    chk("eq_result", out_result, 5'h0A);
    beat(5'h15, 4'b0000, 4'b0001, 1'b0, 3'd3);
    chk("ne_write", out_write, 1'b0);
    chk("ne_result", out_result, 5'h15);
    chk("ne_valid", out_valid, 1'b1);
    beat(5'h03, 4'b1000, 4'b0001, 1'b1, 3'd4);
    chk("sq_write", out_write, 1'b0);
    chk("sq_flags", flags_q, 4'b0100);
    beat(5'h07, 4'b1001, 4'b1110, 1'b1, 3'd5);
    chk("fw_flags", flags_q, 4'b1001);
    beat(5'h08, 4'b0000, 4'b1010, 1'b0, 3'd6);
    chk("ge_write", out_write, 1'b1);
    beat(5'h09, 4'b0000, 4'b1011, 1'b0, 3'd6);
    chk("lt_write", out_write, 1'b0);
    beat(5'h0B, 4'b0000, 4'b1100, 1'b0, 3'd6);
    chk("gt_write", out_write, 1'b1);
    beat(5'h0C, 4'b0000, 4'b1101, 1'b0, 3'd6);
    chk("le_write", out_write, 1'b0);
    beat(5'h0D, 4'b0010, 4'b1110, 1'b1, 3'd0);
    chk("c_flags", flags_q, 4'b0010);
    beat(5'h0E, 4'b0000, 4'b1000, 1'b0, 3'd1);
    chk("hi_write", out_write, 1'b1);
    beat(5'h0F, 4'b0000, 4'b1001, 1'b0, 3'd2);
    chk("ls_write", out_write, 1'b0);
    chk("ls_dest", out_dest, 3'd2);

    out_ready    = 1'b0;
    in_valid     = 1'b1;
    in_result    = 5'h1F;
    in_flags     = 4'b1111;
    in_cond      = 4'b1110;
    in_set_flags = 1'b1;
    in_dest      = 3'd7;
    #1;
    chk("bp_in_ready0", in_ready, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", out_valid, 1'b1);
      chk("bp_result", out_result, 5'h0F);
      chk("bp_dest", out_dest, 3'd2);
      chk("bp_flags", flags_q, 4'b0010);
      chk("bp_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("drain_result", out_result, 5'h1F);
    chk("drain_dest", out_dest, 3'd7);
    chk("drain_write", out_write, 1'b1);
    chk("drain_flags", flags_q, 4'b1111);
    chk("drain_valid", out_valid, 1'b1);
    @(posedge clk); #1;
    chk("drain_empty", out_valid, 1'b0);
    chk("drain_hold_flags", flags_q, 4'b1111);
`ifdef ALU_COND_STATS_EN
    chk("exec_count", exec_count, 8'd8);
    chk("squash_count", squash_count, 8'd5);
`endif

    out_ready = 1'b0;
    beat(5'h11, 4'b0110, 4'b1110, 1'b1, 3'd3);
    chk("stall_valid", out_valid, 1'b1);
    chk("stall_flags", flags_q, 4'b0110);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rs_valid", out_valid, 1'b0);
    chk("rs_flags", flags_q, 4'b0000);
    chk("rs_write", out_write, 1'b0);
    chk("rs_in_ready", in_ready, 1'b1);
`ifdef ALU_COND_STATS_EN
    chk("rs_exec", exec_count, 8'd0);
    chk("rs_squash", squash_count, 8'd0);
`endif
    @(posedge clk); #1;
    chk("rs_idle_valid", out_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
